muldiv_controller: RTL and testbench
====================================

# muldiv_controller

Multi-cycle sequencer for the CPU's multiply/divide resource. It accepts a MULT/DIV request from the control unit with the A and B register operands, and runs a 32-iteration shift-add multiply or restoring divide. It then writes the architectural HI/LO registers and holds the control unit in its wait state through a busy/done handshake. It sits beside the ALU: A/B feed it, and HI/LO feed the MemtoReg selection.

## Interface
- ITER, 32: iteration count; must equal the operand width.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle request pulse; accepted only in IDLE.
- op  in  1  0 = MULT, 1 = DIV.
- rs_val  in  32  operand from register A (multiplicand or dividend).
- rt_val  in  32  operand from register B (multiplier or divisor).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is committed.
- div_zero  out  1  high with done when DIV is requested with rt_val == 0.
- hi  out  32  HI register: upper product word, or remainder.
- lo  out  32  LO register: lower product word, or quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, start = 1, and DIV with rt_val == 0:
  - go to DONE and latch div_zero = 1.
  - hi and lo are unchanged.
- IDLE, start = 1, otherwise:
  - latch operand magnitudes and result signs (sign of dividend for the remainder, XOR of operand signs for the quotient and product).
  - clear the 64-bit work register, set iter count = 0, go to RUN.
- RUN: one iteration per cycle. Go to FIX after iteration ITER-1.
  - MULT: if multiplier LSB = 1, add the multiplicand to the upper half. Then shift the 65-bit {carry, work} right by 1.
  - DIV: shift {rem, quo} left by 1. If rem ≥ divisor, subtract the divisor and set quo LSB = 1.
- FIX: apply the two's-complement sign corrections, write hi and lo, go to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE. div_zero clears when leaving DONE.
- start while busy is ignored: no queueing and no error.
- op, rs_val and rt_val are sampled only on the accepting edge and may change afterwards.
- Signed semantics:
  - the full 64-bit product is exact;
  - the quotient truncates toward zero and the remainder takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000 and hi = 0 (wraps, no exception).
- hi and lo hold their values until the next successful commit. They are read directly by MFHI/MFLO.

## Timing
- Reset values: state IDLE, busy 0, done 0, div_zero 0, hi 0, lo 0, iter count 0, work registers 0.
- Normal latency: start is sampled at edge E0 and done is high in the cycle after edge E0+ITER+1, i.e. 34 cycles for ITER = 32.
- hi and lo become valid in the same cycle as done.
- Divide-by-zero latency: done and div_zero are high in the cycle after E0.
- busy rises in the cycle after E0 and falls in the cycle after done.
- A new start may be accepted in the first cycle busy is low.
- reset mid-operation: at the next edge the block returns to IDLE, hi/lo clear to 0, and the in-flight result is discarded. No done is produced.
- reset and start in the same cycle: reset wins and start is dropped.

## Configuration
- MULDIV_UNSIGNED_EN defined:
  - adds input `op_unsigned` (1 bit), sampled with op;
  - when it is 1, the sign latch and FIX correction are bypassed (MULTU/DIVU);
  - latency is unchanged and divide-by-zero is still flagged.
- MULDIV_UNSIGNED_EN undefined: the port is absent and every operation is signed.

## Structure
- Shared package `muldiv_pkg`:
  - state encoding (IDLE = 0, RUN = 1, FIX = 2, DONE = 3);
  - op encoding (OP_MULT = 0, OP_DIV = 1);
  - ITER default and the counter width, $clog2(ITER).
- One sub-module, `muldiv_iter_core`, owns the 64-bit work register and the per-iteration add/sub/shift datapath.
  - Driven by load/step/op signals from the FSM.
- The FSM, sign handling and HI/LO registers stay in `muldiv_controller`.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3) → after 34 cycles, done = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, div_zero = 0.
- DIV 100 / 7 → lo = 14, hi = 2. Then DIV 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 5 / 0 → done and div_zero high 1 cycle after start. hi and lo keep their previous values.
- Corner cases:
  - MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0;
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- start pulses at cycles 5 and 20 during one MULT → exactly one done. Then reset at cycle 10 of a new DIV → busy = 0, hi = lo = 0 next cycle, and no done ever fires.
- Unsigned (MULDIV_UNSIGNED_EN defined): MULTU 0xFFFFFFFF × 2 → hi = 1, lo = 0xFFFFFFFE; DIVU 0xFFFFFFFF / 16 → lo = 0x0FFFFFFF, hi = 0xF.

Source files
------------

// File: rtl/muldiv_pkg.sv
//==============================================================================
// Module : muldiv_pkg
// Brief  : Shared encodings and sizing for the multiply/divide sequencer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Magnitude of a two's-complement word; passes the raw value when en is low.
  function automatic logic [ITER-1:0] f_abs(input logic [ITER-1:0] v, input logic en);
    return (en && v[ITER-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
//==============================================================================
// Module : muldiv_iter_core
// Brief  : 64-bit work register with one shift-add / restoring-divide step per cycle.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_op,
  input  logic [ITER-1:0]   i_rs_mag,
  input  logic [ITER-1:0]   i_rt_mag,
  output logic [2*ITER-1:0] o_work
);

  localparam int W = ITER;

  logic              r_op;
  logic [W-1:0]      r_opnd;
  logic [2*W-1:0]    r_work;

  logic [W:0]        w_add;
  logic [W:0]        w_mhi;
  logic [W:0]        w_rem;
  logic [W:0]        w_diff;
  logic [2*W-1:0]    w_next;

  assign w_add  = {1'b0, r_work[2*W-1:W]} + {1'b0, r_opnd};
  assign w_mhi  = r_work[0] ? w_add : {1'b0, r_work[2*W-1:W]};
  // Shifted partial remainder needs one extra bit before the trial subtract.
  assign w_rem  = r_work[2*W-1:W-1];
  assign w_diff = w_rem - {1'b0, r_opnd};

  always_comb begin
    w_next = r_work;
    if (r_op == OP_DIV) begin
      if (!w_diff[W]) w_next = {w_diff[W-1:0], r_work[W-2:0], 1'b1};
      else            w_next = {w_rem[W-1:0],  r_work[W-2:0], 1'b0};
    end else begin
      w_next = {w_mhi, r_work[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_MULT;
      r_opnd <= '0;
      r_work <= '0;
    end else if (i_load) begin
      r_op   <= i_op;
      r_opnd <= (i_op == OP_DIV) ? i_rt_mag : i_rs_mag;
      r_work <= {{W{1'b0}}, ((i_op == OP_DIV) ? i_rs_mag : i_rt_mag)};
    end else if (i_step) begin
      r_work <= w_next;
    end
  end

  assign o_work = r_work;

endmodule

`default_nettype wire

// File: rtl/muldiv_controller.sv
//==============================================================================
// Module : muldiv_controller
// Brief  : MULT/DIV sequencer with HI/LO commit and busy/done handshake.
//          Optional MULDIV_UNSIGNED_EN adds i_op_unsigned for MULTU/DIVU.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module muldiv_controller
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_op,
`ifdef MULDIV_UNSIGNED_EN
  input  logic            i_op_unsigned,
`endif
  input  logic [ITER-1:0] i_rs_val,
  input  logic [ITER-1:0] i_rt_val,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_div_zero,
  output logic [ITER-1:0] o_hi,
  output logic [ITER-1:0] o_lo
);

  localparam int W = ITER;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;

  logic             w_signed;
  logic             w_div_zero;
  logic             w_load;
  logic [W-1:0]     w_rs_mag;
  logic [W-1:0]     w_rt_mag;
  logic [2*W-1:0]   w_work;
  logic [2*W-1:0]   w_prod;
  logic [W-1:0]     w_quo;
  logic [W-1:0]     w_rem;

`ifdef MULDIV_UNSIGNED_EN
  assign w_signed = ~i_op_unsigned;
`else
  assign w_signed = 1'b1;
`endif

  assign w_rs_mag   = f_abs(i_rs_val, w_signed);
  assign w_rt_mag   = f_abs(i_rt_val, w_signed);
  assign w_div_zero = (i_op == OP_DIV) && (i_rt_val == '0);
  assign w_load     = (r_state == S_IDLE) && i_start && !w_div_zero;

  muldiv_iter_core u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (r_state == S_RUN),
    .i_op     (i_op),
    .i_rs_mag (w_rs_mag),
    .i_rt_mag (w_rt_mag),
    .o_work   (w_work)
  );

  // Sign corrections; the magnitude datapath is sign-agnostic.
  assign w_prod = r_neg_q ? (~w_work + 1'b1) : w_work;
  assign w_quo  = r_neg_q ? (~w_work[W-1:0] + 1'b1) : w_work[W-1:0];
  assign w_rem  = r_neg_r ? (~w_work[2*W-1:W] + 1'b1) : w_work[2*W-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_div_zero) begin
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_op    <= i_op;
              r_neg_q <= w_signed & (i_rs_val[W-1] ^ i_rt_val[W-1]);
              r_neg_r <= w_signed & i_rs_val[W-1];
              r_cnt   <= '0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ITER - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_op == OP_DIV) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_dz    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_dz;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_controller.sv
//==============================================================================
// Module : tb_muldiv_controller
// Brief  : Scoreboard bench for muldiv_controller against an arithmetic model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_muldiv_controller;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_op = 1'b0;
`ifdef MULDIV_UNSIGNED_EN
  logic        i_op_unsigned = 1'b0;
`endif
  logic [31:0] i_rs_val = '0;
  logic [31:0] i_rt_val = '0;
  logic        o_busy, o_done, o_div_zero;
  logic [31:0] o_hi, o_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_controller dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_op       (i_op),
`ifdef MULDIV_UNSIGNED_EN
    .i_op_unsigned (i_op_unsigned),
`endif
    .i_rs_val   (i_rs_val),
    .i_rt_val   (i_rt_val),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div_zero (o_div_zero),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  task automatic model(input logic op, input logic uns, input logic [31:0] a,
                       input logic [31:0] b, output exp_t e);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    e.dz  = 1'b0;
    e.due = 33;
    if (op == OP_DIV && b == 32'd0) begin
      e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; e.due = 0;
    end else begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = {32'd0, a};           ub = {32'd0, b};
      if (op == OP_MULT) begin
        if (uns) begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
        else     begin p  = sa * sb; e.hi = p[63:32];  e.lo = p[31:0];  end
      end else begin
        if (uns) begin e.lo = 32'(ua / ub); e.hi = 32'(ua % ub); end
        else begin
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic issue(input logic op, input logic uns, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic ue;
    ue = 1'b0;
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_rs_val = a; i_rt_val = b;
`ifdef MULDIV_UNSIGNED_EN
    i_op_unsigned = uns; ue = uns;
`endif
    model(op, ue, a, b, e);
    @(posedge clk);
    #1;
    e.due = cyc + e.due;
    sbq.push_back(e);
    i_start = 1'b0;
    i_op = $urandom_range(1, 0); i_rs_val = $urandom; i_rt_val = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("done_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  task automatic pulse_start_while_busy(input logic op);
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_rs_val = $urandom; i_rt_val = 32'd0;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c[5];
    c = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(3, 0))
      0:       return c[$urandom_range(4, 0)];
      1:       return $urandom_range(15, 0);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (o_done) begin
      if (sbq.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("hi", {32'd0, o_hi}, {32'd0, e.hi});
        chk("lo", {32'd0, o_lo}, {32'd0, e.lo});
        chk("div_zero", {63'd0, o_div_zero}, {63'd0, e.dz});
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic        op, uns;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, o_busy}, 64'd0);
    chk("reset_done", {63'd0, o_done}, 64'd0);
    chk("reset_dz",   {63'd0, o_div_zero}, 64'd0);
    chk("reset_hi",   {32'd0, o_hi}, 64'd0);
    chk("reset_lo",   {32'd0, o_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(OP_MULT, 1'b0, 32'd7, 32'hFFFF_FFFD);        wait_idle();
    issue(OP_DIV,  1'b0, 32'd100, 32'd7);              wait_idle();
    issue(OP_DIV,  1'b0, 32'hFFFF_FFF9, 32'd2);        wait_idle();
    issue(OP_DIV,  1'b0, 32'd5, 32'd0);                wait_idle();
    issue(OP_MULT, 1'b0, 32'h8000_0000, 32'h8000_0000); wait_idle();
    issue(OP_DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
`ifdef MULDIV_UNSIGNED_EN
    issue(OP_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2);        wait_idle();
    issue(OP_DIV,  1'b1, 32'hFFFF_FFFF, 32'd16);       wait_idle();
`endif

    // Starts during a running MULT must be ignored.
    issue(OP_MULT, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) @(negedge clk);
    chk("busy_running", {63'd0, o_busy}, 64'd1);
    pulse_start_while_busy(OP_DIV);
    repeat (13) @(negedge clk);
    pulse_start_while_busy(OP_MULT);
    wait_idle();
    repeat (40) @(negedge clk);

    // Reset mid-DIV, with a simultaneous start that must be dropped.
    issue(OP_DIV, 1'b0, 32'hDEAD_BEEF, 32'd13);
    repeat (9) @(negedge clk);
    rst = 1'b1; i_start = 1'b1; i_op = OP_MULT;
    @(posedge clk);
    #1;
    sbq.delete();
    m_hi = '0; m_lo = '0;
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_hi", {32'd0, o_hi}, 64'd0);
    chk("rst_lo", {32'd0, o_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0; i_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_dropped", {63'd0, o_busy}, 64'd0);
    repeat (50) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      op  = 1'($urandom_range(1, 0));
      uns = 1'($urandom_range(1, 0));
      a   = pick();
      b   = ($urandom_range(7, 0) == 0) ? 32'd0 : pick();
      issue(op, uns, a, b);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
